hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl.sv | 153 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for a 5-stage MIPS pipeline: load-use bubbles,
// taken-branch squashes, multi-cycle memory freeze with timeout halt, and statistics.
module hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_TIMEOUT    = 15
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      idExMemRead,
  input  logic [REG_ADDR_WIDTH-1:0] idExRt,
  input  logic [REG_ADDR_WIDTH-1:0] ifIdRs,
  input  logic [REG_ADDR_WIDTH-1:0] ifIdRt,
  input  logic                      exMemBranch,
  input  logic                      exMemZero,
  input  logic                      exMemMemRead,
  input  logic                      exMemMemWrite,
  input  logic                      memReady,
  output logic                      pcWrite,
  output logic                      ifIdWrite,
  output logic                      ifIdFlush,
  output logic                      idExFlush,
  output logic                      exMemFlush,
  output logic                      idExHold,
  output logic                      exMemHold,
  output logic                      memRequest,
  output logic                      memTimeout,
  output logic [1:0]                state,
  output logic [15:0]               stallCycles,
  output logic [15:0]               flushCount
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WCW-1:0]   r_wait_count;
  logic [WCW-1:0]   w_wait_count_next;
  logic             r_timeout;
  logic             w_timeout_next;
  logic [15:0]      r_stall;
  logic [15:0]      r_flush;
  logic             w_freeze;
  logic             w_mem_access;
  logic             w_branch_taken;
  logic             w_load_use;

  assign w_mem_access   = exMemMemRead | exMemMemWrite;
  assign w_branch_taken = exMemBranch & exMemZero;
  assign w_load_use     = idExMemRead && (idExRt != '0) &&
                          ((idExRt == ifIdRs) || (idExRt == ifIdRt));

  // Next-state logic; w_freeze selects freeze controls, otherwise advance controls apply.
  always_comb begin
    w_state_next      = r_state;
    w_wait_count_next = r_wait_count;
    w_timeout_next    = r_timeout;
    w_freeze          = 1'b0;
    memRequest        = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        memRequest = w_mem_access;
        if (w_mem_access && !memReady) begin
          w_freeze          = 1'b1;
          w_state_next      = ST_MEM_WAIT;
          w_wait_count_next = WCW'(1);
        end
      end
      ST_MEM_WAIT: begin
        memRequest = w_mem_access;
        if (memReady) begin
          w_state_next      = ST_RUN;
          w_wait_count_next = '0;
        end else if (r_wait_count == WCW'(MEM_TIMEOUT)) begin
          w_freeze       = 1'b1;
          w_state_next   = ST_HALT;
          w_timeout_next = 1'b1;
        end else begin
          w_freeze          = 1'b1;
          w_wait_count_next = r_wait_count + WCW'(1);
        end
      end
      default: begin
        w_freeze = 1'b1;
      end
    endcase
    if (reset) begin
      memRequest = 1'b0;
    end
  end

  // Pipeline register controls; a taken branch outranks a load-use bubble.
  always_comb begin
    pcWrite    = 1'b1;
    ifIdWrite  = 1'b1;
    ifIdFlush  = 1'b0;
    idExFlush  = 1'b0;
    exMemFlush = 1'b0;
    idExHold   = 1'b0;
    exMemHold  = 1'b0;
    if (reset) begin
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      ifIdFlush  = 1'b1;
      idExFlush  = 1'b1;
      exMemFlush = 1'b1;
    end else if (w_freeze) begin
      pcWrite   = 1'b0;
      ifIdWrite = 1'b0;
      idExHold  = 1'b1;
      exMemHold = 1'b1;
    end else if (w_branch_taken) begin
      ifIdFlush  = 1'b1;
      idExFlush  = 1'b1;
      exMemFlush = 1'b1;
    end else if (w_load_use) begin
      pcWrite   = 1'b0;
      ifIdWrite = 1'b0;
      idExFlush = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_wait_count <= '0;
      r_timeout    <= 1'b0;
      r_stall      <= '0;
      r_flush      <= '0;
    end else begin
      r_state      <= w_state_next;
      r_wait_count <= w_wait_count_next;
      r_timeout    <= w_timeout_next;
      if ((r_state != ST_HALT) && !pcWrite && (r_stall != 16'hFFFF)) begin
        r_stall <= r_stall + 16'd1;
      end
      if (exMemFlush && (r_flush != 16'hFFFF)) begin
        r_flush <= r_flush + 16'd1;
      end
    end
  end

  assign state       = r_state;
  assign memTimeout  = r_timeout;
  assign stallCycles = r_stall;
  assign flushCount  = r_flush;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: each scenario pushes expected output vectors
// as it drives stimulus and pops/compares them when the cycle's outputs are sampled.
module tb_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic       lr;
    logic [4:0] ldrt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       br;
    logic       z;
    logic       mr;
    logic       mw;
    logic       rdy;
  } stim_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        idExMemRead;
  logic [4:0]  idExRt, ifIdRs, ifIdRt;
  logic        exMemBranch, exMemZero, exMemMemRead, exMemMemWrite, memReady;
  logic        pcWrite, ifIdWrite, ifIdFlush, idExFlush, exMemFlush;
  logic        idExHold, exMemHold, memRequest, memTimeout;
  logic [1:0]  state;
  logic [15:0] stallCycles, flushCount;

  logic [42:0] sb[$];
  logic [42:0] exp_v;
  logic [42:0] obs;
  int          n_run  = 0;
  int          n_fail = 0;

  assign obs = {pcWrite, ifIdWrite, ifIdFlush, idExFlush, exMemFlush, idExHold, exMemHold,
                memRequest, memTimeout, state, stallCycles, flushCount};

  hazard_ctrl #(.REG_ADDR_WIDTH(5), .MEM_TIMEOUT(4)) dut (
    .clock(clock), .reset(reset),
    .idExMemRead(idExMemRead), .idExRt(idExRt), .ifIdRs(ifIdRs), .ifIdRt(ifIdRt),
    .exMemBranch(exMemBranch), .exMemZero(exMemZero),
    .exMemMemRead(exMemMemRead), .exMemMemWrite(exMemMemWrite), .memReady(memReady),
    .pcWrite(pcWrite), .ifIdWrite(ifIdWrite), .ifIdFlush(ifIdFlush), .idExFlush(idExFlush),
    .exMemFlush(exMemFlush), .idExHold(idExHold), .exMemHold(exMemHold),
    .memRequest(memRequest), .memTimeout(memTimeout), .state(state),
    .stallCycles(stallCycles), .flushCount(flushCount)
  );

  always #5 clock = ~clock;

  function automatic stim_t S(input logic rst, input logic lr, input logic [4:0] ldrt,
                              input logic [4:0] rs, input logic [4:0] rt, input logic br,
                              input logic z, input logic mr, input logic mw, input logic rdy);
    stim_t s;
    s = '{rst: rst, lr: lr, ldrt: ldrt, rs: rs, rt: rt, br: br, z: z, mr: mr, mw: mw, rdy: rdy};
    return s;
  endfunction

  // Expected output vector: flushes {ifId,idEx,exMem}, holds {idEx,exMem}.
  function automatic logic [42:0] mk(input logic pcw, input logic ifw, input logic [2:0] fl,
                                     input logic [1:0] h, input logic mreq, input logic tmo,
                                     input logic [1:0] st, input int stall, input int fc);
    return {pcw, ifw, fl, h, mreq, tmo, st, 16'(stall), 16'(fc)};
  endfunction

  task automatic apply(input stim_t s);
    @(posedge clock);
    #1;
    reset         = s.rst;
    idExMemRead   = s.lr;
    idExRt        = s.ldrt;
    ifIdRs        = s.rs;
    ifIdRt        = s.rt;
    exMemBranch   = s.br;
    exMemZero     = s.z;
    exMemMemRead  = s.mr;
    exMemMemWrite = s.mw;
    memReady      = s.rdy;
  endtask

  task automatic do_reset();
    apply(S(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic test_reset();
    stim_t       s[3];
    logic [42:0] e[3];
    for (int i = 0; i < 2; i++) begin
      s[i]     = stim_t'(22'($urandom));
      s[i].rst = 1'b1;
      e[i]     = mk(0, 0, 3'b111, 2'b00, 0, 0, 2'd0, 0, 0);
    end
    s[2] = S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    e[2] = mk(1, 1, 3'b000, 2'b00, 0, 0, 2'd0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      apply(s[i]);
      sb.push_back(e[i]);
      @(negedge clock);
      exp_v = sb.pop_front();
      n_run++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL reset[%0d]: got %h, expected %h", i, obs, exp_v);
      end else $display("[TB] reset[%0d] ok %h", i, obs);
    end
  endtask

  task automatic test_load_use();
    stim_t       s[5];
    logic [42:0] e[5];
    do_reset();
    s[0] = S(0, 1, 8, 8, 0, 0, 0, 0, 0, 0); e[0] = mk(0, 0, 3'b010, 2'b00, 0, 0, 2'd0, 0, 0);
    s[1] = S(0, 0, 0, 8, 0, 0, 0, 0, 0, 0); e[1] = mk(1, 1, 3'b000, 2'b00, 0, 0, 2'd0, 1, 0);
    s[2] = S(0, 1, 0, 0, 0, 0, 0, 0, 0, 0); e[2] = mk(1, 1, 3'b000, 2'b00, 0, 0, 2'd0, 1, 0);
    s[3] = S(0, 1, 5, 3, 5, 0, 0, 0, 0, 0); e[3] = mk(0, 0, 3'b010, 2'b00, 0, 0, 2'd0, 1, 0);
    s[4] = S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[4] = mk(1, 1, 3'b000, 2'b00, 0, 0, 2'd0, 2, 0);
    for (int i = 0; i < 5; i++) begin
      apply(s[i]);
      sb.push_back(e[i]);
      @(negedge clock);
      exp_v = sb.pop_front();
      n_run++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL load_use[%0d]: got %h, expected %h", i, obs, exp_v);
      end else $display("[TB] load_use[%0d] ok %h", i, obs);
    end
  endtask

  task automatic test_branch();
    stim_t       s[4];
    logic [42:0] e[4];
    do_reset();
    s[0] = S(0, 1, 8, 8, 0, 1, 1, 0, 0, 0); e[0] = mk(1, 1, 3'b111, 2'b00, 0, 0, 2'd0, 0, 0);
    s[1] = S(0, 0, 0, 0, 0, 1, 0, 0, 0, 0); e[1] = mk(1, 1, 3'b000, 2'b00, 0, 0, 2'd0, 0, 1);
    s[2] = S(0, 0, 0, 0, 0, 1, 1, 1, 0, 1); e[2] = mk(1, 1, 3'b111, 2'b00, 1, 0, 2'd0, 0, 1);
    s[3] = S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[3] = mk(1, 1, 3'b000, 2'b00, 0, 0, 2'd0, 0, 2);
    for (int i = 0; i < 4; i++) begin
      apply(s[i]);
      sb.push_back(e[i]);
      @(negedge clock);
      exp_v = sb.pop_front();
      n_run++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL branch[%0d]: got %h, expected %h", i, obs, exp_v);
      end else $display("[TB] branch[%0d] ok %h", i, obs);
    end
  endtask

  task automatic test_mem_wait();
    stim_t       s[9];
    logic [42:0] e[9];
    do_reset();
    s[0] = S(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); e[0] = mk(0, 0, 3'b000, 2'b11, 1, 0, 2'd0, 0, 0);
    s[1] = S(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); e[1] = mk(0, 0, 3'b000, 2'b11, 1, 0, 2'd1, 1, 0);
    s[2] = S(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); e[2] = mk(0, 0, 3'b000, 2'b11, 1, 0, 2'd1, 2, 0);
    s[3] = S(0, 0, 0, 0, 0, 0, 0, 1, 0, 1); e[3] = mk(1, 1, 3'b000, 2'b00, 1, 0, 2'd1, 3, 0);
    s[4] = S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[4] = mk(1, 1, 3'b000, 2'b00, 0, 0, 2'd0, 3, 0);
    s[5] = S(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); e[5] = mk(1, 1, 3'b000, 2'b00, 1, 0, 2'd0, 3, 0);
    s[6] = S(0, 1, 8, 8, 0, 0, 0, 1, 0, 0); e[6] = mk(0, 0, 3'b000, 2'b11, 1, 0, 2'd0, 3, 0);
    s[7] = S(0, 1, 8, 8, 0, 0, 0, 1, 0, 1); e[7] = mk(0, 0, 3'b010, 2'b00, 1, 0, 2'd1, 4, 0);
    s[8] = S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[8] = mk(1, 1, 3'b000, 2'b00, 0, 0, 2'd0, 5, 0);
    for (int i = 0; i < 9; i++) begin
      apply(s[i]);
      sb.push_back(e[i]);
      @(negedge clock);
      exp_v = sb.pop_front();
      n_run++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL mem_wait[%0d]: got %h, expected %h", i, obs, exp_v);
      end else $display("[TB] mem_wait[%0d] ok %h", i, obs);
    end
  endtask

  task automatic test_timeout();
    stim_t       s[15];
    logic [42:0] e[15];
    do_reset();
    s[0]  = S(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); e[0]  = mk(0, 0, 3'b000, 2'b11, 1, 0, 2'd0, 0, 0);
    s[1]  = S(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); e[1]  = mk(0, 0, 3'b000, 2'b11, 1, 0, 2'd1, 1, 0);
    s[2]  = S(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); e[2]  = mk(0, 0, 3'b000, 2'b11, 1, 0, 2'd1, 2, 0);
    s[3]  = S(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); e[3]  = mk(0, 0, 3'b000, 2'b11, 1, 0, 2'd1, 3, 0);
    s[4]  = S(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); e[4]  = mk(0, 0, 3'b000, 2'b11, 1, 0, 2'd1, 4, 0);
    s[5]  = S(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); e[5]  = mk(0, 0, 3'b000, 2'b11, 0, 1, 2'd2, 5, 0);
    s[6]  = S(0, 1, 8, 8, 0, 1, 1, 1, 0, 1); e[6]  = mk(0, 0, 3'b000, 2'b11, 0, 1, 2'd2, 5, 0);
    s[7]  = S(1, 0, 0, 0, 0, 0, 0, 1, 0, 0); e[7]  = mk(0, 0, 3'b111, 2'b00, 0, 1, 2'd2, 5, 0);
    s[8]  = S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[8]  = mk(1, 1, 3'b000, 2'b00, 0, 0, 2'd0, 0, 0);
    s[9]  = S(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); e[9]  = mk(0, 0, 3'b000, 2'b11, 1, 0, 2'd0, 0, 0);
    s[10] = S(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); e[10] = mk(0, 0, 3'b000, 2'b11, 1, 0, 2'd1, 1, 0);
    s[11] = S(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); e[11] = mk(0, 0, 3'b000, 2'b11, 1, 0, 2'd1, 2, 0);
    s[12] = S(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); e[12] = mk(0, 0, 3'b000, 2'b11, 1, 0, 2'd1, 3, 0);
    s[13] = S(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); e[13] = mk(1, 1, 3'b000, 2'b00, 1, 0, 2'd1, 4, 0);
    s[14] = S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[14] = mk(1, 1, 3'b000, 2'b00, 0, 0, 2'd0, 4, 0);
    for (int i = 0; i < 15; i++) begin
      apply(s[i]);
      sb.push_back(e[i]);
      @(negedge clock);
      exp_v = sb.pop_front();
      n_run++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL timeout[%0d]: got %h, expected %h", i, obs, exp_v);
      end else $display("[TB] timeout[%0d] ok %h", i, obs);
    end
  endtask

  task automatic test_saturation();
    int wait_n[3];
    int stall_v[3];
    wait_n[0] = 65534; stall_v[0] = 16'hFFFE;
    wait_n[1] = 1;     stall_v[1] = 16'hFFFF;
    wait_n[2] = 10;    stall_v[2] = 16'hFFFF;
    do_reset();
    apply(S(0, 1, 8, 8, 0, 0, 0, 0, 0, 0));
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      sb.push_back(mk(0, 0, 3'b010, 2'b00, 0, 0, 2'd0, stall_v[i], 0));
      repeat (wait_n[i]) @(negedge clock);
      exp_v = sb.pop_front();
      n_run++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL saturation[%0d]: got %h, expected %h", i, obs, exp_v);
      end else $display("[TB] saturation[%0d] ok %h", i, obs);
    end
  endtask

  initial begin
    reset         = 1'b1;
    idExMemRead   = 1'b0;
    idExRt        = '0;
    ifIdRs        = '0;
    ifIdRt        = '0;
    exMemBranch   = 1'b0;
    exMemZero     = 1'b0;
    exMemMemRead  = 1'b0;
    exMemMemWrite = 1'b0;
    memReady      = 1'b0;
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
